// File: rtl/window3x3_stream.sv
// window3x3_stream: streaming 3x3 neighbourhood generator with ready/valid flow control and border padding.
// Define WINDOW3X3_REPLICATE_BORDER_EN to clamp out-of-image taps to the nearest edge pixel instead of zeroing them.
module window3x3_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_W-1:0]     i_pixel_data,
    input  logic                  i_pixel_data_valid,
    output logic                  o_pixel_ready,
    output logic [9*DATA_W-1:0]   o_window,
    output logic                  o_window_valid,
    input  logic                  i_window_ready,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_eof
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [CW-1:0]     in_col_reg, in_col_next, in_col_inc;
    logic [RW-1:0]     in_row_reg, in_row_next, in_row_inc;
    logic [CW-1:0]     out_col_reg;
    logic [RW-1:0]     out_row_reg;
    logic              ready_en_reg;
    logic              adv, in_fire, eof_held, flush_step, load, step, lb_we;
    logic              at_top, at_bottom, at_left, at_right;

    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb0_rd_reg, lb1_rd_reg;
    logic [DATA_W-1:0] prev1_reg [3];
    logic [DATA_W-1:0] prev2_reg [3];
    logic [DATA_W-1:0] new_col [3];
    logic [DATA_W-1:0] cols [3][3];
    logic [9*DATA_W-1:0] window_next;

    assign adv           = !o_window_valid || i_window_ready;
    assign o_pixel_ready = ready_en_reg && (state_reg != FLUSH) && adv;
    assign in_fire       = i_pixel_data_valid && o_pixel_ready;
    assign eof_held      = o_window_valid && o_eof;
    assign flush_step    = (state_reg == FLUSH) && adv && !eof_held;
    assign load          = ((state_reg == RUN) && in_fire) || flush_step;
    assign step          = in_fire || flush_step;
    assign lb_we         = in_fire && i_reset_n;

    assign in_col_inc = (in_col_reg == COL_LAST) ? '0 : in_col_reg + 1'b1;
    assign in_row_inc = (in_col_reg != COL_LAST) ? in_row_reg :
                        (in_row_reg == ROW_LAST) ? '0 : in_row_reg + 1'b1;

    // FLUSH keeps stepping the column counter so the line memories are read for virtual rows below the image.
    always_comb begin
        state_next  = state_reg;
        in_col_next = in_col_reg;
        in_row_next = in_row_reg;
        if (!i_reset_n) begin
            state_next  = FILL;
            in_col_next = '0;
            in_row_next = '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (in_fire) begin
                        in_col_next = in_col_inc;
                        in_row_next = in_row_inc;
                        if ((in_row_reg == RW'(1)) && (in_col_reg == '0)) begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        in_col_next = in_col_inc;
                        in_row_next = in_row_inc;
                        if ((in_row_reg == ROW_LAST) && (in_col_reg == COL_LAST)) begin
                            state_next = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_step) begin
                        in_col_next = in_col_inc;
                    end else if (eof_held && i_window_ready) begin
                        state_next  = FILL;
                        in_col_next = '0;
                        in_row_next = '0;
                    end
                end
                default: begin
                    state_next  = FILL;
                    in_col_next = '0;
                    in_row_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg  <= FILL;
            in_col_reg <= '0;
            in_row_reg <= '0;
        end else begin
            state_reg  <= state_next;
            in_col_reg <= in_col_next;
            in_row_reg <= in_row_next;
        end
    end

    // Line memories: read address is the column of the next pixel, so the registered read is ready when it arrives.
    always_ff @(posedge i_clk) begin
        if (lb_we) begin
            lb0_mem[in_col_reg] <= i_pixel_data;
        end
        lb0_rd_reg <= lb0_mem[in_col_next];
    end

    always_ff @(posedge i_clk) begin
        if (lb_we) begin
            lb1_mem[in_col_reg] <= lb0_rd_reg;
        end
        lb1_rd_reg <= lb1_mem[in_col_next];
    end

    // cols[column][row]: left/centre come from the shift registers, right is the column arriving now.
    always_comb begin
        new_col[0] = lb1_rd_reg;
        new_col[1] = lb0_rd_reg;
        new_col[2] = (state_reg == FLUSH) ? '0 : i_pixel_data;
        for (int r = 0; r < 3; r++) begin
            cols[0][r] = prev2_reg[r];
            cols[1][r] = prev1_reg[r];
            cols[2][r] = new_col[r];
        end
    end

    assign at_top    = (out_row_reg == '0);
    assign at_bottom = (out_row_reg == ROW_LAST);
    assign at_left   = (out_col_reg == '0);
    assign at_right  = (out_col_reg == COL_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi = gi + 1) begin : g_tap
            localparam logic [1:0] TI = 2'(gi / 3);
            localparam logic [1:0] TJ = 2'(gi % 3);
            logic row_pad, col_pad;
            assign row_pad = ((TI == 2'd0) && at_top)  || ((TI == 2'd2) && at_bottom);
            assign col_pad = ((TJ == 2'd0) && at_left) || ((TJ == 2'd2) && at_right);
`ifdef WINDOW3X3_REPLICATE_BORDER_EN
            assign window_next[DATA_W*gi +: DATA_W] = cols[col_pad ? 2'd1 : TJ][row_pad ? 2'd1 : TI];
`else
            assign window_next[DATA_W*gi +: DATA_W] = (row_pad || col_pad) ? '0 : cols[TJ][TI];
`endif
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ready_en_reg   <= 1'b0;
            o_window       <= '0;
            o_window_valid <= 1'b0;
            o_sof          <= 1'b0;
            o_eol          <= 1'b0;
            o_eof          <= 1'b0;
            out_col_reg    <= '0;
            out_row_reg    <= '0;
            for (int k = 0; k < 3; k++) begin
                prev1_reg[k] <= '0;
                prev2_reg[k] <= '0;
            end
        end else begin
            ready_en_reg <= 1'b1;
            if (step) begin
                prev2_reg <= prev1_reg;
                prev1_reg <= new_col;
            end
            if (adv) begin
                o_window_valid <= load;
                o_sof          <= load && at_top && at_left;
                o_eol          <= load && at_right;
                o_eof          <= load && at_bottom && at_right;
            end
            if (load) begin
                o_window <= window_next;
                if (at_right) begin
                    out_col_reg <= '0;
                    out_row_reg <= at_bottom ? '0 : out_row_reg + 1'b1;
                end else begin
                    out_col_reg <= out_col_reg + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_window3x3_stream.sv
// Directed bench for window3x3_stream on a 4x3 image: basic stream, backpressure, back-to-back frames, mid-frame reset.
`timescale 1ns/1ps
module tb_window3x3_stream;
    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pix;
    logic        pix_valid;
    logic        pix_ready;
    logic [71:0] win;
    logic        win_valid;
    logic        win_ready;
    logic        sof, eol, eof;

    always #5 clk = ~clk;

    window3x3_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk              (clk),
        .i_reset_n          (reset_n),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pix_valid),
        .o_pixel_ready      (pix_ready),
        .o_window           (win),
        .o_window_valid     (win_valid),
        .i_window_ready     (win_ready),
        .o_sof              (sof),
        .o_eol              (eol),
        .o_eof              (eof)
    );

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          cyc = 0;
    int          px_idx = 0;
    int          first_px = -1;
    bit          bp_mode = 0;
    bit          rnd_valid = 0;
    bit          stall_pending = 0;
    logic [75:0] stall_snap;
    logic [7:0]  px_q[$];
    logic [71:0] win_q[$];
    logic [2:0]  flg_q[$];
    int          acc_cyc_q[$];
    int          px_acc_cyc[$];

    task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] win9(input int t0, input int t1, input int t2, input int t3,
                                         input int t4, input int t5, input int t6, input int t7, input int t8);
        return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int rr = r - 1 + i;
                int cc = c - 1 + j;
`ifdef WINDOW3X3_REPLICATE_BORDER_EN
                if (rr < 0) rr = 0;
                if (rr > H - 1) rr = H - 1;
                if (cc < 0) cc = 0;
                if (cc > W - 1) cc = W - 1;
                w[8*(3*i+j) +: 8] = 8'(base + rr*W + cc);
`else
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[8*(3*i+j) +: 8] = 8'(base + rr*W + cc);
`endif
            end
        end
        return w;
    endfunction

    task automatic one_cycle();
        win_ready = bp_mode ? ~win_ready : 1'b1;
        if (px_idx < px_q.size()) begin
            pix       = px_q[px_idx];
            pix_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            pix_valid = 1'b0;
        end
        @(negedge clk);
        if (stall_pending) check_val("hold", 80'({win_valid, sof, eol, eof, win}), 80'(stall_snap));
        stall_pending = 0;
        if (win_valid && !win_ready) begin
            check_val("stall_rdy", 80'(pix_ready), 80'(0));
            stall_pending = 1;
            stall_snap    = {1'b1, sof, eol, eof, win};
        end
        if (win_valid && first_px < 0) first_px = px_idx;
        if (win_valid && win_ready) begin
            $display("cyc %0d window %0d: %h sof=%0b eol=%0b eof=%0b", cyc, win_q.size(), win, sof, eol, eof);
            win_q.push_back(win);
            flg_q.push_back({sof, eol, eof});
            acc_cyc_q.push_back(cyc);
        end
        if (pix_valid && pix_ready) begin
            px_acc_cyc.push_back(cyc);
            px_idx++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int want_win, input int want_px, input int budget, input string tag);
        int n = 0;
        first_px      = -1;
        stall_pending = 0;
        while ((win_q.size() < want_win || px_idx < want_px) && n < budget) begin
            one_cycle();
            n++;
        end
        if (n >= budget) check_val({tag, "_timeout"}, 80'({win_q.size(), px_idx}), 80'({want_win, want_px}));
        for (int k = 0; k < 6; k++) one_cycle();
    endtask

    task automatic do_reset(input string tag);
        reset_n   = 1'b0;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val(tag, 80'({win_valid, sof, eol, eof, pix_ready, win}), 80'(0));
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
    endtask

    task automatic clear_queues();
        px_q.delete();
        win_q.delete();
        flg_q.delete();
        acc_cyc_q.delete();
        px_acc_cyc.delete();
        px_idx = 0;
    endtask

    task automatic load_frame(input int base);
        for (int n = 0; n < W*H; n++) px_q.push_back(8'(base + n));
    endtask

    task automatic check_frame(input int off, input int base, input string tag);
        if (win_q.size() >= off + W*H) begin
            for (int k = 0; k < W*H; k++) begin
                check_val($sformatf("%s_win%0d", tag, k), 80'(win_q[off+k]), 80'(exp_win(base, k / W, k % W)));
                check_val($sformatf("%s_flg%0d", tag, k), 80'(flg_q[off+k]),
                          80'({k == 0, (k % W) == W - 1, k == W*H - 1}));
            end
        end
    endtask

    task automatic check_basic(input string tag);
        logic [71:0] e00, elast;
`ifdef WINDOW3X3_REPLICATE_BORDER_EN
        e00   = win9(1, 1, 2, 1, 1, 2, 5, 5, 6);
        elast = win9(7, 8, 8, 11, 12, 12, 11, 12, 12);
`else
        e00   = win9(0, 0, 0, 0, 1, 2, 0, 5, 6);
        elast = win9(7, 8, 0, 11, 12, 0, 0, 0, 0);
`endif
        check_val({tag, "_count"}, 80'(win_q.size()), 80'(12));
        check_val({tag, "_first_lat"}, 80'(first_px), 80'(6));
        if (win_q.size() >= 12) begin
            check_val({tag, "_w00"}, 80'(win_q[0]), 80'(e00));
            check_val({tag, "_sof"}, 80'(flg_q[0]), 80'(3'b100));
            check_val({tag, "_w11"}, 80'(win_q[5]), 80'(win9(1, 2, 3, 5, 6, 7, 9, 10, 11)));
            check_val({tag, "_wlast"}, 80'(win_q[11]), 80'(elast));
            check_val({tag, "_eof"}, 80'(flg_q[11]), 80'(3'b011));
            check_val({tag, "_thruput"}, 80'(acc_cyc_q[11] - acc_cyc_q[0]), 80'(11));
        end
        check_frame(0, 1, tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        pix       = '0;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        do_reset("rst_init");

        clear_queues();
        load_frame(1);
        run(12, 12, 400, "basic");
        check_basic("basic");

        clear_queues();
        load_frame(1);
        bp_mode   = 1;
        rnd_valid = 1;
        run(12, 12, 800, "bp");
        bp_mode   = 0;
        rnd_valid = 0;
        check_val("bp_count", 80'(win_q.size()), 80'(12));
        check_frame(0, 1, "bp");

        clear_queues();
        load_frame(1);
        load_frame(101);
        run(24, 24, 800, "b2b");
        check_val("b2b_count", 80'(win_q.size()), 80'(24));
        check_frame(0, 1, "b2b_f1");
        check_frame(12, 101, "b2b_f2");
        if (win_q.size() >= 13 && px_acc_cyc.size() >= 13) begin
`ifdef WINDOW3X3_REPLICATE_BORDER_EN
            check_val("b2b_f2_w00", 80'(win_q[12]), 80'(win9(101, 101, 102, 101, 101, 102, 105, 105, 106)));
`else
            check_val("b2b_f2_w00", 80'(win_q[12]), 80'(win9(0, 0, 0, 0, 101, 102, 0, 105, 106)));
`endif
            check_val("b2b_gap", 80'(px_acc_cyc[12] - acc_cyc_q[11]), 80'(1));
        end

        clear_queues();
        load_frame(1);
        run(0, 7, 100, "partial");
        do_reset("rst_mid");
        clear_queues();
        load_frame(1);
        run(12, 12, 400, "post_rst");
        check_basic("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
